key_debouncer: RTL
==================

Name: key_debouncer

Overview:
- Conditions the raw board push-buttons before they reach the combinational lab logic and LED drivers.
- Synchronises each active-low key into clk, debounces it with a per-key stability counter, and presents:
  - a clean active-high level,
  - single-cycle press/release pulses,
  - a per-key toggle state that downstream logic can drive straight onto LEDs.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); legal range 2 .. 2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-key counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- key_sw  input  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to clk, bouncing.
- key_level  output  N_KEYS  debounced level, active-high (1 = pressed).
- key_pressed  output  N_KEYS  one-cycle pulse on accepted press.
- key_released  output  N_KEYS  one-cycle pulse on accepted release.
- key_toggle  output  N_KEYS  flips on every accepted press.

Behaviour:
- One clock; reset is asynchronous and active-low. All flops are cleared by reset_n low, independent of clk.
- Reset values:
  - Synchroniser flops = 1 (released).
  - Counters = 0.
  - key_level, key_pressed, key_released and key_toggle = 0.
- Channels are fully independent. Bit i of every output depends only on key_sw[i].
- Synchroniser: two flops per bit, sync1 <= key_sw, sync2 <= sync1. Only sync2 is used downstream. Apply no logic between the two stages.
- Define mismatch_i = (~sync2[i] != key_level[i]).
- Counter, evaluated per clock edge:
  - If mismatch is 0: counter <= 0.
  - If mismatch is 1 and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If mismatch is 1 and counter == DEBOUNCE_CYCLES-1 (accept):
    - counter <= 0.
    - key_level <= ~key_level.
    - On a 0->1 accept, key_pressed <= 1.
    - On a 1->0 accept, key_released <= 1.
- Pulse outputs are registered. Each is high for exactly one cycle, coincident with the first cycle key_level shows the new value, and is 0 in every other cycle.
- key_toggle <= ~key_toggle on the same edge that sets key_pressed. Releases do not affect it.
- Latency:
  - A clean level change on key_sw that is first sampled at edge E appears on key_level after edge E+1+DEBOUNCE_CYCLES.
  - That is DEBOUNCE_CYCLES+2 edges, counting edge E as the first.
- Glitch rejection:
  - Any return to agreement before the accept edge clears the counter.
  - A bounce train shorter than DEBOUNCE_CYCLES consecutive cycles never changes key_level.
- Counter saturation is impossible by construction: it never exceeds DEBOUNCE_CYCLES-1. Size CNT_W so that DEBOUNCE_CYCLES-1 is representable.
- Simultaneous events:
  - Several keys may accept on the same edge. Each asserts its own pulses.
  - There is no arbitration or priority between keys.
- Reset mid-operation:
  - Any in-flight count is discarded and outputs return to reset values immediately.
  - A key held during reset is treated as a new press after release of reset. It reaches key_level after the full latency, then pulses key_pressed and toggles.
- Deassertion of reset_n is assumed synchronised externally; the block adds no reset synchroniser.

Test Plan:
1. Reset then idle:
   - Stimulus: DEBOUNCE_CYCLES=4, reset_n low for 3 cycles, key_sw=4'hF.
   - Required: all outputs 0 throughout, and still 0 after 20 cycles out of reset.
2. Clean press and release on key 0:
   - Stimulus: key_sw=4'hE held.
   - Required: key_level=4'h1 exactly 6 edges after the first sampling edge; key_pressed=4'h1 for exactly that one cycle; key_toggle=4'h1.
   - Stimulus: then key_sw=4'hF.
   - Required: key_level=0 after 6 edges, key_released=4'h1 for one cycle, key_toggle stays 4'h1.
3. Bounce rejection:
   - Stimulus: key 1 toggles low 3 cycles / high 1 cycle, repeated 5 times, then returns high.
   - Required: key_level[1], key_pressed[1] and key_toggle[1] never change.
   - Stimulus: key 1 then held low 10 cycles.
   - Required: exactly one key_pressed[1] pulse.
4. Simultaneous keys:
   - Stimulus: key_sw goes 4'hF -> 4'h0 on one edge.
   - Required: key_level=4'hF and key_pressed=4'hF on the same cycle. A second full press/release of all keys returns key_toggle to 4'h0.
5. Reset mid-count:
   - Stimulus: key 2 held low; assert reset_n 2 cycles after the counter starts.
   - Required: outputs clear immediately. After reset release with key 2 still low, key_level[2] rises 6 edges later with one key_pressed[2] pulse.
6. Default parameter check:
   - Stimulus: DEBOUNCE_CYCLES=500000, key 3 held low 499999 synchronised cycles, then released.
   - Required: no change on any output.
   - Stimulus: key 3 held low 500000 synchronised cycles.
   - Required: key_level[3]=1 and one key_pressed[3] pulse.

Source files
------------

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronise, debounce and edge-detect active-low push-buttons
//
// Purpose: each raw active-low key is passed through a two-flop synchroniser.
// A per-key counter then requires DEBOUNCE_CYCLES consecutive cycles of
// disagreement with the current debounced level before the level flips.
// Channels are fully independent.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (deassertion synchronised externally)
//   key_sw       raw keys, active-low, asynchronous to clk, bouncing
//   key_level    debounced level, active-high (1 = pressed)
//   key_pressed  one-cycle pulse on the first cycle key_level shows a press
//   key_released one-cycle pulse on the first cycle key_level shows a release
//   key_toggle   flips on every accepted press
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_sw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_released,
  output logic [N_KEYS-1:0] key_toggle
);

  // Counter value on the edge that accepts a new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [N_KEYS-1:0] mismatch;

  // Synchronised key is active-low; a set bit means it disagrees with key_level.
  assign mismatch = (~sync2) ^ key_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '1;
      sync2        <= '1;
      key_level    <= '0;
      key_pressed  <= '0;
      key_released <= '0;
      key_toggle   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1        <= key_sw;
      sync2        <= sync1;
      key_pressed  <= '0;
      key_released <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (!mismatch[i]) begin
          // Any return to agreement discards the partial count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]       <= '0;
          key_level[i] <= ~key_level[i];
          if (!key_level[i]) begin
            key_pressed[i] <= 1'b1;
            key_toggle[i]  <= ~key_toggle[i];
          end else begin
            key_released[i] <= 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule
